// File: rtl/riscv_dtm_sync_core_pkg.sv
// Shared DMI/DTMCS types for the RISC-V debug transport module.
package riscv_dm_pkg;

   localparam int unsigned DTMCS_WIDTH = 32;

   // Request ops and response status share the 2-bit field; status names alias the op values.
   typedef enum logic [1:0] {
      DMI_NOP   = 2'd0,
      DMI_READ  = 2'd1,
      DMI_WRITE = 2'd2,
      DMI_BUSY  = 2'd3
   } dmi_op_e;

   localparam dmi_op_e DMI_SUCCESS = DMI_NOP;
   localparam dmi_op_e DMI_FAILED  = DMI_WRITE;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DRAIN
   } dtm_state_e;

   typedef struct packed {
      logic [13:0] zero1;
      logic        dtmhardreset;
      logic        dmireset;
      logic        zero0;
      logic [2:0]  idle;
      logic [1:0]  dmistat;
      logic [5:0]  abits;
      logic [3:0]  version;
   } dtmcs_t;

   function automatic dtmcs_t dtmcs_fields(input logic [3:0] version,
                                           input logic [5:0] abits,
                                           input logic [1:0] dmistat,
                                           input logic [2:0] idle);
      dtmcs_t d;
      d         = '0;
      d.version = version;
      d.abits   = abits;
      d.dmistat = dmistat;
      d.idle    = idle;
      return d;
   endfunction

endpackage

// File: rtl/riscv_dtm_sync_core_if.sv
// DMI request/response channel between the DTM (master) and the debug module (slave).
interface riscv_dtm_sync_core_if #(
   parameter int unsigned ABITS = 7
);
   logic             req_valid_o;
   logic             req_ready_i;
   logic [ABITS-1:0] req_addr_o;
   logic [31:0]      req_data_o;
   logic [1:0]       req_op_o;
   logic             resp_valid_i;
   logic             resp_ready_o;
   logic [31:0]      resp_data_i;
   logic [1:0]       resp_op_i;

   modport master (
      output req_valid_o, req_addr_o, req_data_o, req_op_o, resp_ready_o,
      input  req_ready_i, resp_valid_i, resp_data_i, resp_op_i
   );

   modport slave (
      input  req_valid_o, req_addr_o, req_data_o, req_op_o, resp_ready_o,
      output req_ready_i, resp_valid_i, resp_data_i, resp_op_i
   );
endinterface

// File: rtl/riscv_dtm_timeout_cnt.sv
// Response watchdog: counts while enabled, pulses expire_c on the last allowed cycle.
module riscv_dtm_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic tck_i,
   input  logic trst_ni,
   input  logic en,
   input  logic clr,
   output logic expire_c
);

   localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   // Saturating counter, held at zero whenever the watchdog is idle.
   always_ff @(posedge tck_i) begin
      if (!trst_ni) begin
         cnt_q <= '0;
      end else if (clr || !en) begin
         cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // A zero timeout disables expiry entirely.
   assign expire_c = (TIMEOUT_CYCLES != 0) && en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/riscv_dtm_sync_core.sv
// TAP-agnostic RISC-V DTM core: DMI/DTMCS DR registers, sticky status and DMI handshake.
module riscv_dtm_sync_core
   import riscv_dm_pkg::*;
#(
   parameter int unsigned ABITS          = 7,
   parameter int unsigned IDLE_CYCLES    = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned VERSION        = 1
) (
   input  logic tck_i,
   input  logic trst_ni,
   input  logic tdi_i,
   input  logic capture_dr_i,
   input  logic shift_dr_i,
   input  logic update_dr_i,
   input  logic dmi_select_i,
   input  logic dtmcs_select_i,
   output logic dmi_tdo_o,
   output logic dtmcs_tdo_o,
   riscv_dtm_sync_core_if.master dmi
);

   localparam int unsigned DMI_WIDTH = ABITS + 34;

   typedef struct packed {
      logic [ABITS-1:0] addr;
      logic [31:0]      data;
      logic [1:0]       op;
   } dmi_t;

   dtm_state_e       state_q, state_d;
   dmi_t             dmi_sr_q, dmi_sr_d;
   dtmcs_t           dtmcs_sr_q, dtmcs_sr_d;
   logic [ABITS-1:0] addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [1:0]       op_q, op_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [1:0]       sticky_q, sticky_d;
   logic             req_valid_q, resp_ready_q;

   logic dmi_capture, dmi_shift, dmi_update;
   logic dtmcs_capture, dtmcs_shift, dtmcs_update;
   logic hardreset, dmireset, busy, sticky_clear, req_start, resp_fire;
   logic tmr_en, tmr_clr, expire_c;

   assign dmi_capture   = dmi_select_i & capture_dr_i;
   assign dmi_shift     = dmi_select_i & shift_dr_i;
   assign dmi_update    = dmi_select_i & update_dr_i;
   assign dtmcs_capture = dtmcs_select_i & capture_dr_i;
   assign dtmcs_shift   = dtmcs_select_i & shift_dr_i;
   assign dtmcs_update  = dtmcs_select_i & update_dr_i;

   assign hardreset    = dtmcs_update & dtmcs_sr_q.dtmhardreset;
   assign dmireset     = dtmcs_update & dtmcs_sr_q.dmireset;
   assign busy         = (state_q != ST_IDLE);
   assign sticky_clear = (sticky_q == 2'(DMI_SUCCESS));
   assign req_start    = dmi_update && sticky_clear && !busy &&
                         ((dmi_sr_q.op == 2'(DMI_READ)) || (dmi_sr_q.op == 2'(DMI_WRITE)));
   assign resp_fire    = (state_q == ST_WAIT) && dmi.resp_valid_i;
   assign tmr_en       = (state_q == ST_WAIT);

   riscv_dtm_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .tck_i   (tck_i),
      .trst_ni (trst_ni),
      .en      (tmr_en),
      .clr     (tmr_clr),
      .expire_c(expire_c)
   );

   always_ff @(posedge tck_i) begin
      if (!trst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Handshake sequencing; a hard reset abandons whatever is in flight.
   always_comb begin
      state_d = state_q;
      tmr_clr = 1'b0;
      case (state_q)
         ST_IDLE:  if (req_start) state_d = ST_REQ;
         ST_REQ: begin
            if (dmi.req_ready_i) begin
               state_d = ST_WAIT;
               tmr_clr = 1'b1;
            end
         end
         ST_WAIT: begin
            if (dmi.resp_valid_i) begin
               state_d = ST_IDLE;
            end else if (expire_c) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: if (dmi.resp_valid_i) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (hardreset) state_d = ST_IDLE;
   end

   // DR registers, latched request and sticky status; later assignments take priority.
   always_comb begin
      dmi_sr_d   = dmi_sr_q;
      dtmcs_sr_d = dtmcs_sr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      op_d       = op_q;
      rdata_d    = rdata_q;
      sticky_d   = sticky_q;

      if (dmi_shift) begin
         dmi_sr_d = dmi_t'({tdi_i, dmi_sr_q[DMI_WIDTH-1:1]});
      end else if (dmi_capture) begin
         dmi_sr_d.addr = addr_q;
         dmi_sr_d.data = rdata_q;
         dmi_sr_d.op   = busy ? 2'(DMI_BUSY) : sticky_q;
      end

      if (req_start) begin
         addr_d  = dmi_sr_q.addr;
         wdata_d = dmi_sr_q.data;
         op_d    = dmi_sr_q.op;
      end

      if (dtmcs_shift) begin
         dtmcs_sr_d = dtmcs_t'({tdi_i, dtmcs_sr_q[DTMCS_WIDTH-1:1]});
      end else if (dtmcs_capture) begin
         dtmcs_sr_d = dtmcs_fields(4'(VERSION), 6'(ABITS), sticky_q, 3'(IDLE_CYCLES));
      end

      if (resp_fire) begin
         if (!hardreset) rdata_d = dmi.resp_data_i;
         if ((dmi.resp_op_i != 2'(DMI_SUCCESS)) && sticky_clear) sticky_d = dmi.resp_op_i;
      end else if ((state_q == ST_WAIT) && expire_c) begin
         sticky_d = 2'(DMI_FAILED);
      end

      // Touching the DMI register while a transfer is outstanding is a busy error.
      if (busy && (dmi_capture || (dmi_update && sticky_clear))) sticky_d = 2'(DMI_BUSY);
      if (dmireset || hardreset) sticky_d = 2'(DMI_SUCCESS);
   end

   always_ff @(posedge tck_i) begin
      if (!trst_ni) begin
         dmi_sr_q     <= '0;
         dtmcs_sr_q   <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         op_q         <= '0;
         rdata_q      <= '0;
         sticky_q     <= '0;
         req_valid_q  <= 1'b0;
         resp_ready_q <= 1'b0;
      end else begin
         dmi_sr_q     <= dmi_sr_d;
         dtmcs_sr_q   <= dtmcs_sr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         op_q         <= op_d;
         rdata_q      <= rdata_d;
         sticky_q     <= sticky_d;
         req_valid_q  <= (state_d == ST_REQ);
         resp_ready_q <= (state_d == ST_WAIT) || (state_d == ST_DRAIN);
      end
   end

   assign dmi_tdo_o        = dmi_sr_q[0];
   assign dtmcs_tdo_o      = dtmcs_sr_q[0];
   assign dmi.req_valid_o  = req_valid_q;
   assign dmi.req_addr_o   = addr_q;
   assign dmi.req_data_o   = wdata_q;
   assign dmi.req_op_o     = op_q;
   assign dmi.resp_ready_o = resp_ready_q;

endmodule

// File: tb/tb_riscv_dtm_sync_core.sv
// Directed bench for riscv_dtm_sync_core: DMI read/write, busy, timeout, hardreset and reset.
module tb_riscv_dtm_sync_core;

   localparam int unsigned DW = 41;
   localparam logic [31:0] DTMCS_OK   = 32'h0000_1071;
   localparam logic [31:0] DTMCS_FAIL = 32'h0000_1871;
   localparam logic [31:0] DTMCS_BUSY = 32'h0000_1C71;

   logic tck = 1'b0;
   logic trst_ni, tdi, capture_dr, shift_dr, update_dr, dmi_sel, dtmcs_sel;
   logic dmi_tdo, dtmcs_tdo, dmi_tdo12, dtmcs_tdo12;
   int   vectors = 0;
   int   miscompares = 0;

   riscv_dtm_sync_core_if #(.ABITS(7))  bus ();
   riscv_dtm_sync_core_if #(.ABITS(12)) bus12 ();

   assign bus12.req_ready_i  = 1'b1;
   assign bus12.resp_valid_i = 1'b0;
   assign bus12.resp_data_i  = 32'h0;
   assign bus12.resp_op_i    = 2'd0;

   riscv_dtm_sync_core #(.ABITS(7), .IDLE_CYCLES(1), .TIMEOUT_CYCLES(8), .VERSION(1)) dut (
      .tck_i(tck), .trst_ni(trst_ni), .tdi_i(tdi), .capture_dr_i(capture_dr),
      .shift_dr_i(shift_dr), .update_dr_i(update_dr), .dmi_select_i(dmi_sel),
      .dtmcs_select_i(dtmcs_sel), .dmi_tdo_o(dmi_tdo), .dtmcs_tdo_o(dtmcs_tdo),
      .dmi(bus.master)
   );

   riscv_dtm_sync_core #(.ABITS(12), .IDLE_CYCLES(1), .TIMEOUT_CYCLES(8), .VERSION(1)) dut12 (
      .tck_i(tck), .trst_ni(trst_ni), .tdi_i(tdi), .capture_dr_i(capture_dr),
      .shift_dr_i(shift_dr), .update_dr_i(update_dr), .dmi_select_i(dmi_sel),
      .dtmcs_select_i(dtmcs_sel), .dmi_tdo_o(dmi_tdo12), .dtmcs_tdo_o(dtmcs_tdo12),
      .dmi(bus12.master)
   );

   always #5 tck = ~tck;

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   task automatic dmi_scan(input logic [DW-1:0] din, output logic [DW-1:0] dout);
      dmi_sel = 1'b1; capture_dr = 1'b1; tick(); capture_dr = 1'b0;
      shift_dr = 1'b1;
      for (int i = 0; i < int'(DW); i++) begin
         tdi = din[i]; dout[i] = dmi_tdo; tick();
      end
      shift_dr = 1'b0; tdi = 1'b0;
      update_dr = 1'b1; tick(); update_dr = 1'b0; dmi_sel = 1'b0;
   endtask

   task automatic dtmcs_scan(input logic [31:0] din, output logic [31:0] dout, output logic [31:0] dout12);
      dtmcs_sel = 1'b1; capture_dr = 1'b1; tick(); capture_dr = 1'b0;
      shift_dr = 1'b1;
      for (int i = 0; i < 32; i++) begin
         tdi = din[i]; dout[i] = dtmcs_tdo; dout12[i] = dtmcs_tdo12; tick();
      end
      shift_dr = 1'b0; tdi = 1'b0;
      update_dr = 1'b1; tick(); update_dr = 1'b0; dtmcs_sel = 1'b0;
   endtask

   task automatic dm_respond(input logic [31:0] data, input logic [1:0] op);
      bus.req_ready_i = 1'b1; tick(); bus.req_ready_i = 1'b0;
      bus.resp_valid_i = 1'b1; bus.resp_data_i = data; bus.resp_op_i = op; tick();
      bus.resp_valid_i = 1'b0; bus.resp_data_i = 32'h0; bus.resp_op_i = 2'd0;
   endtask

   task automatic test_reset();
      logic [31:0] d, d12;
      trst_ni = 1'b0; repeat (2) tick(); trst_ni = 1'b1;
      vectors++; if (bus.req_valid_o !== 1'b0 || bus.resp_ready_o !== 1'b0) begin
         miscompares++; $display("FAIL reset_handshake: got %b%b want 00", bus.req_valid_o, bus.resp_ready_o); end
      vectors++; if (dmi_tdo !== 1'b0 || dtmcs_tdo !== 1'b0) begin
         miscompares++; $display("FAIL reset_tdo: got %b%b want 00", dmi_tdo, dtmcs_tdo); end
      dtmcs_scan(32'h0, d, d12);
      vectors++; if (d !== DTMCS_OK) begin
         miscompares++; $display("FAIL dtmcs_reset: got %h want %h", d, DTMCS_OK); end
      vectors++; if (d12 !== 32'h0000_10C1) begin
         miscompares++; $display("FAIL dtmcs_abits12: got %h want %h", d12, 32'h0000_10C1); end
   endtask

   task automatic test_write();
      logic [DW-1:0] d, e;
      dmi_scan({7'h10, 32'h1, 2'd2}, d);
      vectors++; if (d !== '0) begin
         miscompares++; $display("FAIL write_first_capture: got %h want 0", d); end
      vectors++; if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== 7'h10 || bus.req_data_o !== 32'h1 || bus.req_op_o !== 2'd2) begin
         miscompares++; $display("FAIL write_req: got v=%b a=%h d=%h op=%0d want v=1 a=10 d=1 op=2",
                                 bus.req_valid_o, bus.req_addr_o, bus.req_data_o, bus.req_op_o); end
      tick();
      vectors++; if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== 7'h10) begin
         miscompares++; $display("FAIL write_req_hold: got v=%b a=%h want v=1 a=10", bus.req_valid_o, bus.req_addr_o); end
      bus.req_ready_i = 1'b1; tick(); bus.req_ready_i = 1'b0;
      vectors++; if (bus.req_valid_o !== 1'b0 || bus.resp_ready_o !== 1'b1) begin
         miscompares++; $display("FAIL write_wait: got v=%b rr=%b want v=0 rr=1", bus.req_valid_o, bus.resp_ready_o); end
      bus.resp_valid_i = 1'b1; bus.resp_data_i = 32'h0; bus.resp_op_i = 2'd0; tick(); bus.resp_valid_i = 1'b0;
      vectors++; if (bus.resp_ready_o !== 1'b0) begin
         miscompares++; $display("FAIL write_idle: got rr=%b want 0", bus.resp_ready_o); end
      dmi_scan('0, d);
      e = {7'h10, 32'h0, 2'd0};
      vectors++; if (d !== e) begin
         miscompares++; $display("FAIL write_status: got %h want %h", d, e); end
      vectors++; if (bus.req_valid_o !== 1'b0) begin
         miscompares++; $display("FAIL nop_update: got v=%b want 0", bus.req_valid_o); end
   endtask

   task automatic test_read();
      logic [DW-1:0] d, e;
      dmi_scan({7'h11, 32'h0, 2'd1}, d);
      vectors++; if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== 7'h11 || bus.req_op_o !== 2'd1) begin
         miscompares++; $display("FAIL read_req: got v=%b a=%h op=%0d want v=1 a=11 op=1",
                                 bus.req_valid_o, bus.req_addr_o, bus.req_op_o); end
      dm_respond(32'hDEADBEEF, 2'd0);
      dmi_scan('0, d);
      e = {7'h11, 32'hDEADBEEF, 2'd0};
      vectors++; if (d !== e) begin
         miscompares++; $display("FAIL read_data: got %h want %h", d, e); end
   endtask

   task automatic test_busy();
      logic [DW-1:0] d, e;
      logic [31:0]   t, t12;
      dmi_scan({7'h12, 32'h5, 2'd2}, d);
      bus.req_ready_i = 1'b1; tick(); bus.req_ready_i = 1'b0;
      dmi_sel = 1'b1; capture_dr = 1'b1; tick(); capture_dr = 1'b0; dmi_sel = 1'b0;
      bus.resp_valid_i = 1'b1; bus.resp_data_i = 32'hCAFE0001; tick();
      bus.resp_valid_i = 1'b0; bus.resp_data_i = 32'h0;
      dmi_sel = 1'b1; shift_dr = 1'b1;
      for (int i = 0; i < int'(DW); i++) begin
         tdi = 1'b0; d[i] = dmi_tdo; tick();
      end
      shift_dr = 1'b0; update_dr = 1'b1; tick(); update_dr = 1'b0; dmi_sel = 1'b0;
      e = {7'h12, 32'hDEADBEEF, 2'd3};
      vectors++; if (d !== e) begin
         miscompares++; $display("FAIL busy_capture: got %h want %h", d, e); end
      dtmcs_scan(32'h0, t, t12);
      vectors++; if (t !== DTMCS_BUSY) begin
         miscompares++; $display("FAIL busy_dmistat: got %h want %h", t, DTMCS_BUSY); end
      dmi_scan({7'h13, 32'h7, 2'd2}, d);
      e = {7'h12, 32'hCAFE0001, 2'd3};
      vectors++; if (d !== e) begin
         miscompares++; $display("FAIL busy_sticky_capture: got %h want %h", d, e); end
      vectors++; if (bus.req_valid_o !== 1'b0) begin
         miscompares++; $display("FAIL busy_blocks_req: got v=%b want 0", bus.req_valid_o); end
      dtmcs_scan(32'h0001_0000, t, t12);
      dtmcs_scan(32'h0, t, t12);
      vectors++; if (t !== DTMCS_OK) begin
         miscompares++; $display("FAIL dmireset: got %h want %h", t, DTMCS_OK); end
      dmi_scan({7'h13, 32'h7, 2'd2}, d);
      vectors++; if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== 7'h13) begin
         miscompares++; $display("FAIL after_dmireset_req: got v=%b a=%h want v=1 a=13", bus.req_valid_o, bus.req_addr_o); end
      dm_respond(32'h0, 2'd0);
   endtask

   task automatic test_timeout();
      logic [DW-1:0] d, e;
      logic [31:0]   t, t12;
      dmi_scan({7'h14, 32'h9, 2'd2}, d);
      bus.req_ready_i = 1'b1; tick(); bus.req_ready_i = 1'b0;
      repeat (8) tick();
      vectors++; if (bus.resp_ready_o !== 1'b1) begin
         miscompares++; $display("FAIL drain_ready: got rr=%b want 1", bus.resp_ready_o); end
      dtmcs_scan(32'h0, t, t12);
      vectors++; if (t !== DTMCS_FAIL) begin
         miscompares++; $display("FAIL timeout_dmistat: got %h want %h", t, DTMCS_FAIL); end
      bus.resp_valid_i = 1'b1; bus.resp_data_i = 32'h12345678; tick();
      bus.resp_valid_i = 1'b0; bus.resp_data_i = 32'h0;
      vectors++; if (bus.resp_ready_o !== 1'b0) begin
         miscompares++; $display("FAIL drain_to_idle: got rr=%b want 0", bus.resp_ready_o); end
      dmi_scan('0, d);
      e = {7'h14, 32'h0, 2'd2};
      vectors++; if (d !== e) begin
         miscompares++; $display("FAIL late_resp_discarded: got %h want %h", d, e); end
      dtmcs_scan(32'h0001_0000, t, t12);
      // Response in the last allowed WAIT cycle must beat the timeout.
      dmi_scan({7'h1A, 32'h3, 2'd1}, d);
      bus.req_ready_i = 1'b1; tick(); bus.req_ready_i = 1'b0;
      repeat (7) tick();
      bus.resp_valid_i = 1'b1; bus.resp_data_i = 32'hA5A5A5A5; tick();
      bus.resp_valid_i = 1'b0; bus.resp_data_i = 32'h0;
      dtmcs_scan(32'h0, t, t12);
      vectors++; if (t !== DTMCS_OK) begin
         miscompares++; $display("FAIL edge_resp_status: got %h want %h", t, DTMCS_OK); end
      dmi_scan('0, d);
      e = {7'h1A, 32'hA5A5A5A5, 2'd0};
      vectors++; if (d !== e) begin
         miscompares++; $display("FAIL edge_resp_data: got %h want %h", d, e); end
   endtask

   task automatic test_resp_error();
      logic [DW-1:0] d;
      logic [31:0]   t, t12;
      dmi_scan({7'h1B, 32'h0, 2'd1}, d);
      dm_respond(32'h0BAD0BAD, 2'd2);
      dtmcs_scan(32'h0, t, t12);
      vectors++; if (t !== DTMCS_FAIL) begin
         miscompares++; $display("FAIL resp_failed_dmistat: got %h want %h", t, DTMCS_FAIL); end
      dtmcs_scan(32'h0001_0000, t, t12);
   endtask

   task automatic test_hardreset();
      logic [DW-1:0] d, e;
      logic [31:0]   t, t12;
      dmi_scan({7'h15, 32'h0, 2'd1}, d);
      e = {7'h1B, 32'h0BAD0BAD, 2'd0};
      vectors++; if (d !== e || bus.req_valid_o !== 1'b1) begin
         miscompares++; $display("FAIL hr_setup: got %h v=%b want %h v=1", d, bus.req_valid_o, e); end
      dmi_scan('0, d);
      e = {7'h15, 32'h0BAD0BAD, 2'd3};
      vectors++; if (d !== e || bus.req_valid_o !== 1'b1) begin
         miscompares++; $display("FAIL req_busy_capture: got %h v=%b want %h v=1", d, bus.req_valid_o, e); end
      dtmcs_scan(32'h0002_0000, t, t12);
      vectors++; if (t !== DTMCS_BUSY || bus.req_valid_o !== 1'b0) begin
         miscompares++; $display("FAIL hardreset_drop: got %h v=%b want %h v=0", t, bus.req_valid_o, DTMCS_BUSY); end
      dtmcs_scan(32'h0, t, t12);
      vectors++; if (t !== DTMCS_OK) begin
         miscompares++; $display("FAIL hardreset_clear: got %h want %h", t, DTMCS_OK); end
      dmi_scan({7'h16, 32'h77, 2'd2}, d);
      vectors++; if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== 7'h16 || bus.req_data_o !== 32'h77) begin
         miscompares++; $display("FAIL hr_new_req: got v=%b a=%h d=%h want v=1 a=16 d=77",
                                 bus.req_valid_o, bus.req_addr_o, bus.req_data_o); end
   endtask

   task automatic test_trst();
      logic [DW-1:0] d;
      logic [31:0]   t, t12;
      bus.req_ready_i = 1'b1; tick(); bus.req_ready_i = 1'b0;
      dmi_sel = 1'b1; capture_dr = 1'b1; tick(); dmi_sel = 1'b0;
      dtmcs_sel = 1'b1; tick(); capture_dr = 1'b0; dtmcs_sel = 1'b0;
      vectors++; if (bus.resp_ready_o !== 1'b1 || dmi_tdo !== 1'b1 || dtmcs_tdo !== 1'b1) begin
         miscompares++; $display("FAIL pre_trst: got rr=%b tdo=%b%b want 1 11", bus.resp_ready_o, dmi_tdo, dtmcs_tdo); end
      trst_ni = 1'b0; tick();
      vectors++; if (bus.req_valid_o !== 1'b0 || bus.resp_ready_o !== 1'b0 || dmi_tdo !== 1'b0 || dtmcs_tdo !== 1'b0 ||
                     bus.req_addr_o !== 7'h0 || bus.req_data_o !== 32'h0 || bus.req_op_o !== 2'd0) begin
         miscompares++; $display("FAIL trst_outputs: got v=%b rr=%b tdo=%b%b a=%h d=%h op=%0d want all 0",
                                 bus.req_valid_o, bus.resp_ready_o, dmi_tdo, dtmcs_tdo,
                                 bus.req_addr_o, bus.req_data_o, bus.req_op_o); end
      trst_ni = 1'b1; tick();
      dmi_scan('0, d);
      vectors++; if (d !== '0) begin
         miscompares++; $display("FAIL trst_dmi_state: got %h want 0", d); end
      dtmcs_scan(32'h0, t, t12);
      vectors++; if (t !== DTMCS_OK) begin
         miscompares++; $display("FAIL trst_dtmcs: got %h want %h", t, DTMCS_OK); end
   endtask

   initial begin
      trst_ni = 1'b0; tdi = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
      dmi_sel = 1'b0; dtmcs_sel = 1'b0;
      bus.req_ready_i = 1'b0; bus.resp_valid_i = 1'b0; bus.resp_data_i = 32'h0; bus.resp_op_i = 2'd0;
      test_reset();
      test_write();
      test_read();
      test_busy();
      test_timeout();
      test_resp_error();
      test_hardreset();
      test_trst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
